// File: rtl/md5_group_sequencer.sv
// md5_group_sequencer: services HPS message slots one at a time. Each slot's
// 16 message words are fetched into core_block, the MD5 core is launched,
// and the 128-bit digest is written back as four 32-bit words.
module md5_group_sequencer #(
    parameter int NUM_SLOTS  = 8,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic         clk_clk,
    input  logic         reset_reset_n,
    input  logic [31:0]  md5_start,
    input  logic [31:0]  md5_reset,
    output logic [31:0]  md5_done,
    output logic [6:0]   md5_readaddr,
    input  logic [31:0]  md5_readdata,
    output logic         md5_wr,
    output logic [8:0]   md5_writeaddr,
    output logic [31:0]  md5_writedata,
    output logic [511:0] core_block,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_digest
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0]    FETCH_LAST = 5'(15 + RD_LATENCY);
    localparam logic [4:0]    CAP_FIRST  = 5'(RD_LATENCY);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, STORE} state_t;

    state_t               state, state_d;
    logic [2:0]           slot, slot_d;
    logic [4:0]           fcnt, fcnt_d;
    logic [TW-1:0]        tcnt, tcnt_d;
    logic [1:0]           scnt, scnt_d;
    logic [127:0]         digest, digest_d;
    logic [NUM_SLOTS-1:0] done_r, done_d;
    logic                 err, err_d;
    logic [6:0]           readaddr_d;
    logic                 wr_d;
    logic [8:0]           writeaddr_d;
    logic [31:0]          writedata_d;
    logic [511:0]         block_d;
    logic                 cstart_d;

    logic [NUM_SLOTS-1:0] start_v, pend, slot_mask;
    logic [2:0]           sel;
    logic                 found;
    logic                 go_store;
    logic                 unused_ok;

    assign start_v   = md5_start[NUM_SLOTS-1:0];
    assign md5_done  = {err, {(31 - NUM_SLOTS){1'b0}}, done_r};
    assign unused_ok = ^{md5_reset[31:1], md5_start};

    // Registers: FSM state plus every output and datapath register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            slot          <= '0;
            fcnt          <= '0;
            tcnt          <= '0;
            scnt          <= '0;
            digest        <= '0;
            done_r        <= '0;
            err           <= 1'b0;
            md5_readaddr  <= '0;
            md5_wr        <= 1'b0;
            md5_writeaddr <= '0;
            md5_writedata <= '0;
            core_block    <= '0;
            core_start    <= 1'b0;
        end else begin
            state         <= state_d;
            slot          <= slot_d;
            fcnt          <= fcnt_d;
            tcnt          <= tcnt_d;
            scnt          <= scnt_d;
            digest        <= digest_d;
            done_r        <= done_d;
            err           <= err_d;
            md5_readaddr  <= readaddr_d;
            md5_wr        <= wr_d;
            md5_writeaddr <= writeaddr_d;
            md5_writedata <= writedata_d;
            core_block    <= block_d;
            core_start    <= cstart_d;
        end
    end

    // Next-state and next-output logic; soft reset overrides everything last
    always_comb begin
        state_d     = state;
        slot_d      = slot;
        fcnt_d      = fcnt;
        tcnt_d      = tcnt;
        scnt_d      = scnt;
        digest_d    = digest;
        err_d       = err;
        readaddr_d  = md5_readaddr;
        wr_d        = md5_wr;
        writeaddr_d = md5_writeaddr;
        writedata_d = md5_writedata;
        block_d     = core_block;
        cstart_d    = core_start;
        go_store    = 1'b0;
        sel         = '0;
        found       = 1'b0;
        slot_mask   = '0;

        pend = start_v & ~done_r;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (pend[i] && !found) begin
                sel   = 3'(i);
                found = 1'b1;
            end
            slot_mask[i] = (slot == 3'(i));
        end

        // A withdrawn request drops its done flag in every state
        done_d = done_r & start_v;

        case (state)
            IDLE: begin
                if (found && !md5_reset[0]) begin
                    state_d    = FETCH;
                    slot_d     = sel;
                    fcnt_d     = '0;
                    readaddr_d = {sel, 4'b0000};
                end
            end
            FETCH: begin
                if (fcnt < 5'd15) begin
                    readaddr_d = md5_readaddr + 7'd1;
                end
                // Words shift in from the top so word 0 ends up in bits [31:0]
                if (fcnt >= CAP_FIRST) begin
                    block_d = {md5_readdata, core_block[511:32]};
                end
                if (fcnt == FETCH_LAST) begin
                    state_d  = LAUNCH;
                    cstart_d = 1'b1;
                end else begin
                    fcnt_d = fcnt + 5'd1;
                end
            end
            LAUNCH: begin
                cstart_d = 1'b0;
                state_d  = WAIT;
                tcnt_d   = '0;
            end
            WAIT: begin
                if (core_done) begin
                    digest_d    = core_digest;
                    writedata_d = core_digest[31:0];
                    go_store    = 1'b1;
                end else if (tcnt == TMO_LAST) begin
                    digest_d    = '1;
                    writedata_d = '1;
                    err_d       = 1'b1;
                    go_store    = 1'b1;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
                if (go_store) begin
                    state_d     = STORE;
                    wr_d        = 1'b1;
                    writeaddr_d = {4'b0000, slot, 2'b00};
                    scnt_d      = '0;
                end
            end
            STORE: begin
                if (scnt == 2'd3) begin
                    wr_d    = 1'b0;
                    state_d = IDLE;
                    done_d  = done_d | (slot_mask & start_v);
                end else begin
                    // Digest shifts down so the next word is always in [63:32]
                    scnt_d      = scnt + 2'd1;
                    writeaddr_d = md5_writeaddr + 9'd1;
                    writedata_d = digest[63:32];
                    digest_d    = {32'h0, digest[127:32]};
                end
            end
            default: state_d = IDLE;
        endcase

        if (md5_reset[0]) begin
            state_d  = IDLE;
            done_d   = '0;
            err_d    = 1'b0;
            wr_d     = 1'b0;
            cstart_d = 1'b0;
        end
    end

endmodule
